pcpi_master: RTL and testbench

PCPI_MASTER -- requirements
Module: pcpi_master

---
 rtl/pcpi_master_pkg.sv | 53 +++++
 rtl/pcpi_master_if.sv | 44 ++++
 rtl/pcpi_timeout_cnt.sv | 32 +++
 rtl/pcpi_master.sv | 139 +++++++++++++
 tb/tb_pcpi_master.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pcpi_master_pkg.sv
// Shared types and constants for the PCPI master: FSM states, response error
// codes, bus payload structs, default limits and R-type encoding helpers.
package pcpi_master_pkg;

    localparam int unsigned XLEN           = 32;
    localparam int unsigned ERR_W          = 2;
    localparam int unsigned TIMEOUT_DEF    = 16;
    localparam int unsigned WDOG_LIMIT_DEF = 256;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    typedef logic [ERR_W-1:0] rsp_err_t;

    localparam rsp_err_t ERR_NONE    = 2'b00;
    localparam rsp_err_t ERR_TIMEOUT = 2'b01;
    localparam rsp_err_t ERR_WDOG    = 2'b10;

    // Latched command presented on the PCPI request side
    typedef struct packed {
        logic [XLEN-1:0] insn;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
    } pcpi_req_t;

    // Response payload held until the consumer takes it
    typedef struct packed {
        logic [XLEN-1:0] rd;
        logic            wr;
        rsp_err_t        err;
    } pcpi_rsp_t;

    // RV32M R-type encodings
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
    localparam logic [2:0] F3_MUL        = 3'b000;
    localparam logic [2:0] F3_DIV        = 3'b100;
    localparam logic [2:0] F3_DIVU       = 3'b101;
    localparam logic [2:0] F3_REM        = 3'b110;
    localparam logic [2:0] F3_REMU       = 3'b111;

    function automatic logic [XLEN-1:0] mk_rtype(input logic [6:0] funct7,
                                                 input logic [2:0] funct3,
                                                 input logic [4:0] rd,
                                                 input logic [4:0] rs1,
                                                 input logic [4:0] rs2);
        return {funct7, rs2, rs1, funct3, rd, OPCODE_OP};
    endfunction

endpackage

// File: rtl/pcpi_master_if.sv
// Command, PCPI request/response and result handshake bundle for pcpi_master.
interface pcpi_master_if;
    import pcpi_master_pkg::*;

    logic            cmd_valid;
    logic            cmd_ready;
    logic [XLEN-1:0] cmd_insn;
    logic [XLEN-1:0] cmd_rs1;
    logic [XLEN-1:0] cmd_rs2;

    logic            pcpi_valid;
    logic [XLEN-1:0] pcpi_insn;
    logic [XLEN-1:0] pcpi_rs1;
    logic [XLEN-1:0] pcpi_rs2;
    logic            pcpi_wr;
    logic [XLEN-1:0] pcpi_rd;
    logic            pcpi_wait;
    logic            pcpi_ready;

    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_rd;
    logic            rsp_wr;
    rsp_err_t        rsp_err;

    modport master (
        input  cmd_valid, cmd_insn, cmd_rs1, cmd_rs2,
        output cmd_ready,
        output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
        input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
        output rsp_valid, rsp_rd, rsp_wr, rsp_err,
        input  rsp_ready
    );

    modport slave (
        output cmd_valid, cmd_insn, cmd_rs1, cmd_rs2,
        input  cmd_ready,
        input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
        output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
        input  rsp_valid, rsp_rd, rsp_wr, rsp_err,
        output rsp_ready
    );

endinterface

// File: rtl/pcpi_timeout_cnt.sv
// Clearable saturating cycle counter; tc_c flags the cycle whose increment
// would reach LIMIT, so the owner can act on that same edge.
module pcpi_timeout_cnt
    import pcpi_master_pkg::*;
#(
    parameter int unsigned LIMIT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic tc_c
);

    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    // Clear wins over increment; holds at LIMIT once reached
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != CW'(LIMIT))) begin
            count <= count + CW'(1);
        end
    end

    assign tc_c = inc && !clr && (count >= CW'(LIMIT - 1));

endmodule

// File: rtl/pcpi_master.sv
// PCPI issue master: accepts one command, drives it onto PCPI until the
// coprocessor answers or gives up, then holds the response for the consumer.
// Optional watchdog on total ISSUE cycles: define PCPI_MASTER_WATCHDOG_EN.
module pcpi_master
    import pcpi_master_pkg::*;
#(
    parameter int unsigned TIMEOUT    = TIMEOUT_DEF,
    parameter int unsigned WDOG_LIMIT = WDOG_LIMIT_DEF
) (
    input  logic          clk,
    input  logic          reset,
    pcpi_master_if.master bus
);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("pcpi_master: TIMEOUT must be at least 1");
    end
    if (WDOG_LIMIT < 1) begin : g_bad_wdog
        $error("pcpi_master: WDOG_LIMIT must be at least 1");
    end

    state_t    state, state_next;
    pcpi_req_t req, req_next;
    pcpi_rsp_t rsp, rsp_next;

    logic cmd_ready_q;
    logic pcpi_valid_q;
    logic rsp_valid_q;

    logic in_issue_c;
    logic to_tc_c;
    logic wdog_tc_c;

    assign in_issue_c = (state == ST_ISSUE);

    // Counts consecutive ISSUE cycles in which the coprocessor shows no sign of life
    pcpi_timeout_cnt #(
        .LIMIT (TIMEOUT)
    ) u_timeout (
        .clk   (clk),
        .reset (reset),
        .clr   (!in_issue_c || bus.pcpi_wait),
        .inc   (in_issue_c),
        .tc_c  (to_tc_c)
    );

`ifdef PCPI_MASTER_WATCHDOG_EN
    // Bounds total ISSUE time even while the coprocessor keeps asserting wait
    pcpi_timeout_cnt #(
        .LIMIT (WDOG_LIMIT)
    ) u_wdog (
        .clk   (clk),
        .reset (reset),
        .clr   (!in_issue_c),
        .inc   (in_issue_c),
        .tc_c  (wdog_tc_c)
    );
`else
    assign wdog_tc_c = 1'b0;
`endif

    // Next state and next payload; a coprocessor answer beats any abort in the same cycle
    always_comb begin
        state_next = state;
        req_next   = req;
        rsp_next   = rsp;

        case (state)
            ST_IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    state_next   = ST_ISSUE;
                    req_next.insn = bus.cmd_insn;
                    req_next.rs1  = bus.cmd_rs1;
                    req_next.rs2  = bus.cmd_rs2;
                end
            end

            ST_ISSUE: begin
                if (bus.pcpi_ready) begin
                    state_next  = ST_RESP;
                    rsp_next.rd  = bus.pcpi_rd;
                    rsp_next.wr  = bus.pcpi_wr;
                    rsp_next.err = ERR_NONE;
                end else if (wdog_tc_c) begin
                    state_next  = ST_RESP;
                    rsp_next.rd  = '0;
                    rsp_next.wr  = 1'b0;
                    rsp_next.err = ERR_WDOG;
                end else if (to_tc_c) begin
                    state_next  = ST_RESP;
                    rsp_next.rd  = '0;
                    rsp_next.wr  = 1'b0;
                    rsp_next.err = ERR_TIMEOUT;
                end
            end

            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State, payload and handshake flags; flags follow next state so each is
    // already correct in the first cycle of the state it belongs to
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            req          <= '0;
            rsp          <= '0;
            cmd_ready_q  <= 1'b0;
            pcpi_valid_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
        end else begin
            state        <= state_next;
            req          <= req_next;
            rsp          <= rsp_next;
            cmd_ready_q  <= (state_next == ST_IDLE);
            pcpi_valid_q <= (state_next == ST_ISSUE);
            rsp_valid_q  <= (state_next == ST_RESP);
        end
    end

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.pcpi_valid = pcpi_valid_q;
    assign bus.pcpi_insn  = req.insn;
    assign bus.pcpi_rs1   = req.rs1;
    assign bus.pcpi_rs2   = req.rs2;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_rd     = rsp.rd;
    assign bus.rsp_wr     = rsp.wr;
    assign bus.rsp_err    = rsp.err;

endmodule

// File: tb/tb_pcpi_master.sv
// Self-checking bench for pcpi_master with a divide-only coprocessor model and
// a cycle-count reference derived from the timeout/watchdog rules.
module tb_pcpi_master;
    import pcpi_master_pkg::*;

    localparam int TB_TIMEOUT  = 16;
    localparam int TB_WDOG     = 256;
    localparam int ISSUE_BOUND = 1000;

    typedef struct {
        string       name;
        logic [31:0] insn;
        logic [31:0] rs1;
        logic [31:0] rs2;
        int          resp_cycle;
        int          wait_every;
        int          hold;
        int          exp_len;
        logic [31:0] exp_rd;
        logic        exp_wr;
        logic [1:0]  exp_err;
    } txn_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int checks = 0;
    int errors = 0;

    int cur_resp       = 0;
    int cur_wait_every = 0;
    int cop_k          = 0;

    txn_t tbl[$];

    pcpi_master_if bus();

    pcpi_master #(
        .TIMEOUT    (TB_TIMEOUT),
        .WDOG_LIMIT (TB_WDOG)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_time_limit: got running expected finished");
        $fatal(1, "time limit");
    end

    function automatic bit is_div(input logic [31:0] insn);
        return (insn[6:0] == OPCODE_OP) && (insn[31:25] == FUNCT7_MULDIV) && insn[14];
    endfunction

    // RV32M divide semantics including divide-by-zero and signed overflow
    function automatic logic [31:0] div_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        bit ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (f3 == F3_DIV) begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (ovf) return a;
            return 32'(sa / sb);
        end else if (f3 == F3_DIVU) begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            return a / b;
        end else if (f3 == F3_REM) begin
            if (b == 32'd0) return a;
            if (ovf) return 32'd0;
            return 32'(sa % sb);
        end
        if (b == 32'd0) return a;
        return a % b;
    endfunction

    function automatic bit wait_at(input bit d, input int k, input int we);
        return d && (we != 0) && ((k % we) == 0);
    endfunction

    // Expected ISSUE length and response, walking the cycles one by one
    function automatic txn_t ref_txn(input txn_t t);
        txn_t r;
        bit   d;
        int   run;
        r         = t;
        d         = is_div(t.insn);
        run       = 0;
        r.exp_len = ISSUE_BOUND;
        r.exp_rd  = 32'd0;
        r.exp_wr  = 1'b0;
        r.exp_err = ERR_TIMEOUT;
        for (int k = 1; k <= ISSUE_BOUND; k++) begin
            if (d && (k == t.resp_cycle)) begin
                r.exp_len = k;
                r.exp_rd  = div_ref(t.insn[14:12], t.rs1, t.rs2);
                r.exp_wr  = 1'b1;
                r.exp_err = ERR_NONE;
                return r;
            end
`ifdef PCPI_MASTER_WATCHDOG_EN
            if (k == TB_WDOG) begin
                r.exp_len = k;
                r.exp_err = ERR_WDOG;
                return r;
            end
`endif
            if (wait_at(d, k, t.wait_every)) run = 0;
            else run++;
            if (run >= TB_TIMEOUT) begin
                r.exp_len = k;
                r.exp_err = ERR_TIMEOUT;
                return r;
            end
        end
        return r;
    endfunction

    // Divide-only coprocessor: recognises DIV/DIVU/REM/REMU, answers on a chosen
    // ISSUE cycle; all response pins are random whenever they must be ignored
    always @(negedge clk) begin
        if (reset || (bus.pcpi_valid !== 1'b1)) begin
            cop_k          = 0;
            bus.pcpi_ready = 1'($urandom);
            bus.pcpi_wait  = 1'($urandom);
            bus.pcpi_rd    = $urandom;
            bus.pcpi_wr    = 1'($urandom);
        end else begin
            cop_k = cop_k + 1;
            if (is_div(bus.pcpi_insn) && (cop_k == cur_resp)) begin
                bus.pcpi_ready = 1'b1;
                bus.pcpi_wait  = 1'($urandom);
                bus.pcpi_rd    = div_ref(bus.pcpi_insn[14:12], bus.pcpi_rs1, bus.pcpi_rs2);
                bus.pcpi_wr    = 1'b1;
            end else begin
                bus.pcpi_ready = 1'b0;
                bus.pcpi_wait  = wait_at(is_div(bus.pcpi_insn), cop_k, cur_wait_every);
                bus.pcpi_rd    = $urandom;
                bus.pcpi_wr    = 1'($urandom);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input string name, input logic [2:0] f3, input logic [31:0] rs1,
                           input logic [31:0] rs2, input int resp, input int we, input int hold,
                           input int len, input logic [31:0] rd, input logic wr, input logic [1:0] err);
        txn_t t;
        t.name       = name;
        t.insn       = mk_rtype(FUNCT7_MULDIV, f3, 5'd10, 5'd11, 5'd12);
        t.rs1        = rs1;
        t.rs2        = rs2;
        t.resp_cycle = resp;
        t.wait_every = we;
        t.hold       = hold;
        t.exp_len    = len;
        t.exp_rd     = rd;
        t.exp_wr     = wr;
        t.exp_err    = err;
        tbl.push_back(t);
    endtask

    task automatic run_txn(input txn_t t);
        int n;
        int bad;
        int len;
        n = 0;
        while ((bus.cmd_ready !== 1'b1) && (n < 50)) begin
            @(negedge clk);
            n++;
        end
        chk({t.name, " idle_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
        if (bus.cmd_ready !== 1'b1) return;

        cur_resp       = t.resp_cycle;
        cur_wait_every = t.wait_every;
        bus.cmd_valid  = 1'b1;
        bus.cmd_insn   = t.insn;
        bus.cmd_rs1    = t.rs1;
        bus.cmd_rs2    = t.rs2;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_insn  = $urandom;
        bus.cmd_rs1   = $urandom;
        bus.cmd_rs2   = $urandom;
        chk({t.name, " accept_valid_ready"}, 32'({bus.pcpi_valid, bus.cmd_ready}), 32'(2'b10));

        len = 0;
        bad = 0;
        while ((bus.pcpi_valid === 1'b1) && (len < ISSUE_BOUND)) begin
            len++;
            if ((bus.pcpi_insn !== t.insn) || (bus.pcpi_rs1 !== t.rs1) || (bus.pcpi_rs2 !== t.rs2) ||
                (bus.cmd_ready !== 1'b0) || (bus.rsp_valid !== 1'b0)) bad++;
            @(negedge clk);
        end
        chk({t.name, " issue_cycles"}, 32'(len), 32'(t.exp_len));
        chk({t.name, " issue_stable"}, 32'(bad), 32'd0);
        chk({t.name, " rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
        chk({t.name, " rsp_rd"}, bus.rsp_rd, t.exp_rd);
        chk({t.name, " rsp_wr_err"}, 32'({bus.rsp_wr, bus.rsp_err}), 32'({t.exp_wr, t.exp_err}));

        bad = 0;
        for (int i = 0; i < t.hold; i++) begin
            @(negedge clk);
            if ((bus.rsp_valid !== 1'b1) || (bus.rsp_rd !== t.exp_rd) || (bus.rsp_wr !== t.exp_wr) ||
                (bus.rsp_err !== t.exp_err) || (bus.cmd_ready !== 1'b0) || (bus.pcpi_valid !== 1'b0)) bad++;
        end
        if (t.hold > 0) chk({t.name, " rsp_hold_stable"}, 32'(bad), 32'd0);

        // Offer a new command during the handshake cycle; it must not be taken
        bus.rsp_ready = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_insn  = $urandom;
        chk({t.name, " handshake_cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.cmd_valid = 1'b0;
        chk({t.name, " post_rsp_valid_pcpi_ready"},
            32'({bus.rsp_valid, bus.pcpi_valid, bus.cmd_ready}), 32'(3'b001));
    endtask

    initial begin
        txn_t t;
        int   n;
        int   we_choice[5];
        we_choice     = '{0, 1, 3, 16, 17};
        bus.cmd_valid = 1'b0;
        bus.cmd_insn  = 32'd0;
        bus.cmd_rs1   = 32'd0;
        bus.cmd_rs2   = 32'd0;
        bus.rsp_ready = 1'b0;
        reset         = 1'b1;

        repeat (3) @(negedge clk);
        chk("reset_flags", 32'({bus.cmd_ready, bus.pcpi_valid, bus.rsp_valid}), 32'd0);
        chk("reset_pcpi_insn", bus.pcpi_insn, 32'd0);
        chk("reset_pcpi_ops", bus.pcpi_rs1 | bus.pcpi_rs2, 32'd0);
        chk("reset_rsp_payload", bus.rsp_rd, 32'd0);
        chk("reset_rsp_wr_err", 32'({bus.rsp_wr, bus.rsp_err}), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        add_vec("div_100_7",        F3_DIV,  32'd100,         32'd7,           6,  1, 0,  6,  32'd14,          1'b1, ERR_NONE);
        add_vec("rem_neg100_7",     F3_REM,  32'hFFFF_FF9C,   32'd7,           3,  1, 1,  3,  32'hFFFF_FFFE,   1'b1, ERR_NONE);
        add_vec("divu_by_zero",     F3_DIVU, 32'd5,           32'd0,           1,  1, 0,  1,  32'hFFFF_FFFF,   1'b1, ERR_NONE);
        add_vec("mul_unclaimed",    F3_MUL,  32'd3,           32'd4,           5,  1, 0,  16, 32'd0,           1'b0, ERR_TIMEOUT);
        add_vec("hold_ten",         F3_DIV,  32'd1000,        32'hFFFF_FFFD,   4,  1, 10, 4,  32'hFFFF_FEB3,   1'b1, ERR_NONE);
        add_vec("ready_at_limit",   F3_REMU, 32'd17,          32'd5,           16, 0, 0,  16, 32'd2,           1'b1, ERR_NONE);
        add_vec("ready_past_limit", F3_DIV,  32'd17,          32'd5,           17, 0, 0,  16, 32'd0,           1'b0, ERR_TIMEOUT);
        add_vec("wait_every_16",    F3_REMU, 32'h8000_0000,   32'd3,           40, 16, 2, 40, 32'd2,           1'b1, ERR_NONE);
        add_vec("wait_every_17",    F3_REMU, 32'h8000_0000,   32'd3,           40, 17, 0, 16, 32'd0,           1'b0, ERR_TIMEOUT);
        add_vec("div_overflow",     F3_DIV,  32'h8000_0000,   32'hFFFF_FFFF,   2,  1, 1,  2,  32'h8000_0000,   1'b1, ERR_NONE);

        foreach (tbl[i]) run_txn(tbl[i]);

        // Reset while a DIV sits in ISSUE: nothing may come out of it
        cur_resp       = 200;
        cur_wait_every = 1;
        bus.cmd_valid  = 1'b1;
        bus.cmd_insn   = mk_rtype(FUNCT7_MULDIV, F3_DIV, 5'd1, 5'd2, 5'd3);
        bus.cmd_rs1    = 32'd100;
        bus.cmd_rs2    = 32'd7;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("midreset_in_issue", 32'(bus.pcpi_valid), 32'd1);
        reset = 1'b1;
        #1;
        chk("midreset_async_flags", 32'({bus.pcpi_valid, bus.rsp_valid, bus.cmd_ready}), 32'd0);
        chk("midreset_async_insn", bus.pcpi_insn, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n = 0;
        @(negedge clk);
        chk("midreset_release_flags", 32'({bus.cmd_ready, bus.pcpi_valid, bus.rsp_valid}), 32'(3'b100));
        repeat (3) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0) n++;
        end
        chk("midreset_no_response", 32'(n), 32'd0);

        // Coprocessor that keeps waiting past the watchdog limit
        t.name       = "long_wait";
        t.insn       = mk_rtype(FUNCT7_MULDIV, F3_DIVU, 5'd4, 5'd5, 5'd6);
        t.rs1        = 32'd77;
        t.rs2        = 32'd7;
        t.resp_cycle = 300;
        t.wait_every = 1;
        t.hold       = 1;
        run_txn(ref_txn(t));

        for (int i = 0; i < 40; i++) begin
            logic [2:0] f3;
            f3     = 3'($urandom_range(0, 7));
            t.name = $sformatf("rand%0d", i);
            if ($urandom_range(0, 7) == 0) t.insn = $urandom;
            else t.insn = mk_rtype(FUNCT7_MULDIV, f3, 5'($urandom), 5'($urandom), 5'($urandom));
            t.rs1 = ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0:       t.rs2 = 32'd0;
                1:       t.rs2 = 32'hFFFF_FFFF;
                default: t.rs2 = $urandom;
            endcase
            t.resp_cycle = $urandom_range(1, 24);
            t.wait_every = we_choice[$urandom_range(0, 4)];
            t.hold       = $urandom_range(0, 3);
            run_txn(ref_txn(t));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
